// File: rtl/grf_pkg.sv
// Shared defaults and limits for the multi-port register file and its scoreboard.
package grf_pkg;
  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int NUM_RD_MIN = 1;
  localparam int NUM_RD_MAX = 4;
  localparam int NUM_WR_MIN = 1;
  localparam int NUM_WR_MAX = 2;
  localparam int ZERO_ADDR  = 0;
endpackage

// File: rtl/grf_scoreboard.sv
// Per-register pending-producer bits: alloc sets, effective writes clear, alloc wins on a tie.
module grf_scoreboard
  import grf_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     alloc_en,
  input  logic [ADDR_W-1:0]        alloc_addr,
  input  logic [NUM_WR-1:0]        wr_eff,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD-1:0]        rd_busy
);
  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] ZA = ADDR_W'(ZERO_ADDR);

  logic [DEPTH-1:0] busy;
  logic [DEPTH-1:0] busy_nxt;
  logic [DEPTH-1:0] clr_mask;
  logic [DEPTH-1:0] set_mask;

  always_comb begin
    clr_mask = '0;
    set_mask = '0;
    for (int j = 0; j < NUM_WR; j++)
      if (wr_eff[j]) clr_mask[wr_addr[j*ADDR_W +: ADDR_W]] = 1'b1;
    if (alloc_en && !((ZERO_REG != 0) && (alloc_addr == ZA)))
      set_mask[alloc_addr] = 1'b1;
    busy_nxt = (busy & ~clr_mask) | set_mask;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) busy <= '0;
    else       busy <= busy_nxt;
  end

  // A write landing this cycle already satisfies the reader, so it masks the hazard.
  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic              hit;
    assign addr = rd_addr[k*ADDR_W +: ADDR_W];
    always_comb begin
      hit = 1'b0;
      for (int j = 0; j < NUM_WR; j++)
        if (wr_eff[j] && (wr_addr[j*ADDR_W +: ADDR_W] == addr)) hit = 1'b1;
    end
    assign rd_busy[k] = busy[addr] && !hit && !((ZERO_REG != 0) && (addr == ZA));
  end
endmodule

// File: rtl/grf_mp.sv
// Multi-port register file with same-cycle write bypass, scoreboard and registered commit trace.
module grf_mp
  import grf_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
  input  logic [NUM_WR*DATA_W-1:0] wr_data,
  input  logic [NUM_WR*32-1:0]     wr_pc,
  input  logic                     alloc_en,
  input  logic [ADDR_W-1:0]        alloc_addr,
  output logic [NUM_WR-1:0]        trace_valid,
  output logic [NUM_WR*ADDR_W-1:0] trace_addr,
  output logic [NUM_WR*DATA_W-1:0] trace_data,
  output logic [NUM_WR*32-1:0]     trace_pc
);
  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] ZA = ADDR_W'(ZERO_ADDR);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [NUM_WR-1:0] wr_req;
  logic [NUM_WR-1:0] wr_eff;

  function automatic logic is_zero(input logic [ADDR_W-1:0] a);
    return (ZERO_REG != 0) && (a == ZA);
  endfunction

  // The youngest (highest-index) port targeting an address shadows all older ones.
  always_comb begin
    wr_req = '0;
    for (int j = 0; j < NUM_WR; j++)
      wr_req[j] = wr_en[j] && !is_zero(wr_addr[j*ADDR_W +: ADDR_W]);
    wr_eff = wr_req;
    for (int j = 0; j < NUM_WR; j++)
      for (int i = j + 1; i < NUM_WR; i++)
        if (wr_req[i] && (wr_addr[i*ADDR_W +: ADDR_W] == wr_addr[j*ADDR_W +: ADDR_W]))
          wr_eff[j] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      for (int j = 0; j < NUM_WR; j++)
        if (wr_eff[j]) mem[wr_addr[j*ADDR_W +: ADDR_W]] <= wr_data[j*DATA_W +: DATA_W];
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    assign addr = rd_addr[k*ADDR_W +: ADDR_W];
    always_comb begin
      data = mem[addr];
      for (int j = 0; j < NUM_WR; j++)
        if (wr_eff[j] && (wr_addr[j*ADDR_W +: ADDR_W] == addr)) data = wr_data[j*DATA_W +: DATA_W];
      if (is_zero(addr)) data = '0;
    end
    assign rd_data[k*DATA_W +: DATA_W] = data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      trace_valid <= '0;
      trace_addr  <= '0;
      trace_data  <= '0;
      trace_pc    <= '0;
    end else begin
      trace_valid <= wr_eff;
      for (int j = 0; j < NUM_WR; j++) begin
        if (wr_eff[j]) begin
          trace_addr[j*ADDR_W +: ADDR_W] <= wr_addr[j*ADDR_W +: ADDR_W];
          trace_data[j*DATA_W +: DATA_W] <= wr_data[j*DATA_W +: DATA_W];
          trace_pc[j*32 +: 32]           <= wr_pc[j*32 +: 32];
        end
      end
    end
  end

  grf_scoreboard #(
    .ADDR_W  (ADDR_W),
    .NUM_RD  (NUM_RD),
    .NUM_WR  (NUM_WR),
    .ZERO_REG(ZERO_REG)
  ) u_sb (
    .clk       (clk),
    .reset     (reset),
    .alloc_en  (alloc_en),
    .alloc_addr(alloc_addr),
    .wr_eff    (wr_eff),
    .wr_addr   (wr_addr),
    .rd_addr   (rd_addr),
    .rd_busy   (rd_busy)
  );
endmodule

// File: tb/tb_grf_mp.sv
// Bench for grf_mp: a dual-write instance and a single-write instance sharing reads and alloc.
module tb_grf_mp;
  logic        clk = 1'b0;
  logic        reset;
  logic [14:0] rd_addr;
  logic        alloc_en;
  logic [4:0]  alloc_addr;

  logic [95:0] rd_data_a;
  logic [2:0]  busy_a;
  logic [1:0]  wr_en_a;
  logic [9:0]  wr_addr_a;
  logic [63:0] wr_data_a;
  logic [63:0] wr_pc_a;
  logic [1:0]  tv_a;
  logic [9:0]  ta_a;
  logic [63:0] td_a;
  logic [63:0] tp_a;

  logic [95:0] rd_data_b;
  logic [2:0]  busy_b;
  logic [0:0]  wr_en_b;
  logic [4:0]  wr_addr_b;
  logic [31:0] wr_data_b;
  logic [31:0] wr_pc_b;
  logic [0:0]  tv_b;
  logic [4:0]  ta_b;
  logic [31:0] td_b;
  logic [31:0] tp_b;

  always #20 clk = ~clk;

  grf_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(3), .NUM_WR(2), .ZERO_REG(1)) dut_a (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data_a), .rd_busy(busy_a),
    .wr_en(wr_en_a), .wr_addr(wr_addr_a), .wr_data(wr_data_a), .wr_pc(wr_pc_a),
    .alloc_en(alloc_en), .alloc_addr(alloc_addr),
    .trace_valid(tv_a), .trace_addr(ta_a), .trace_data(td_a), .trace_pc(tp_a)
  );

  grf_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(3), .NUM_WR(1), .ZERO_REG(1)) dut_b (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_busy(busy_b),
    .wr_en(wr_en_b), .wr_addr(wr_addr_b), .wr_data(wr_data_b), .wr_pc(wr_pc_b),
    .alloc_en(alloc_en), .alloc_addr(alloc_addr),
    .trace_valid(tv_b), .trace_addr(ta_b), .trace_data(td_b), .trace_pc(tp_b)
  );

  int total = 0;
  int passed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  // Reference state: architectural register values and pending flags per instance.
  logic [31:0] ma [32];
  logic [31:0] mb [32];
  bit          pa [32];
  bit          pb [32];

  function automatic bit written_a(input logic [4:0] a);
    return (a != 0) && ((wr_en_a[0] && wr_addr_a[4:0] == a) || (wr_en_a[1] && wr_addr_a[9:5] == a));
  endfunction

  function automatic bit written_b(input logic [4:0] a);
    return (a != 0) && wr_en_b[0] && (wr_addr_b == a);
  endfunction

  function automatic logic [31:0] exp_rd_a(input logic [4:0] a);
    if (a == 0) return 32'd0;
    if (wr_en_a[1] && wr_addr_a[9:5] == a) return wr_data_a[63:32];
    if (wr_en_a[0] && wr_addr_a[4:0] == a) return wr_data_a[31:0];
    return ma[a];
  endfunction

  function automatic logic [31:0] exp_rd_b(input logic [4:0] a);
    if (a == 0) return 32'd0;
    if (wr_en_b[0] && wr_addr_b == a) return wr_data_b;
    return mb[a];
  endfunction

  function automatic logic [4:0] raddr();
    if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
    return 5'($urandom_range(0, 7));
  endfunction

  typedef struct {
    logic [1:0]  we;
    logic [4:0]  wa0;
    logic [4:0]  wa1;
    logic [31:0] wd0;
    logic [31:0] wd1;
    logic        ae;
    logic [4:0]  aa;
    logic [4:0]  ra;
    logic [31:0] exp_rd;
    logic        exp_busy;
    logic [1:0]  exp_tv;
  } vec_t;

  vec_t tbl [12];

  initial begin
    logic [1:0]  etv;
    logic [4:0]  a;

    tbl[0]  = '{2'b01, 5'd3, 5'd0, 32'h1234_5678, 32'h0,         1'b0, 5'd0, 5'd3, 32'h1234_5678, 1'b0, 2'b01};
    tbl[1]  = '{2'b00, 5'd0, 5'd0, 32'h0,         32'h0,         1'b0, 5'd0, 5'd3, 32'h1234_5678, 1'b0, 2'b00};
    tbl[2]  = '{2'b11, 5'd7, 5'd7, 32'hAAAA_AAAA, 32'h5555_5555, 1'b0, 5'd0, 5'd7, 32'h5555_5555, 1'b0, 2'b10};
    tbl[3]  = '{2'b00, 5'd0, 5'd0, 32'h0,         32'h0,         1'b0, 5'd0, 5'd7, 32'h5555_5555, 1'b0, 2'b00};
    tbl[4]  = '{2'b01, 5'd0, 5'd0, 32'hFFFF_FFFF, 32'h0,         1'b1, 5'd0, 5'd0, 32'h0,         1'b0, 2'b00};
    tbl[5]  = '{2'b00, 5'd0, 5'd0, 32'h0,         32'h0,         1'b0, 5'd0, 5'd0, 32'h0,         1'b0, 2'b00};
    tbl[6]  = '{2'b00, 5'd0, 5'd0, 32'h0,         32'h0,         1'b1, 5'd9, 5'd9, 32'h0,         1'b0, 2'b00};
    tbl[7]  = '{2'b00, 5'd0, 5'd0, 32'h0,         32'h0,         1'b0, 5'd0, 5'd9, 32'h0,         1'b1, 2'b00};
    tbl[8]  = '{2'b10, 5'd0, 5'd9, 32'h0,         32'h0000_0099, 1'b0, 5'd0, 5'd9, 32'h0000_0099, 1'b0, 2'b10};
    tbl[9]  = '{2'b00, 5'd0, 5'd0, 32'h0,         32'h0,         1'b0, 5'd0, 5'd9, 32'h0000_0099, 1'b0, 2'b00};
    tbl[10] = '{2'b01, 5'd9, 5'd0, 32'h0000_0077, 32'h0,         1'b1, 5'd9, 5'd9, 32'h0000_0077, 1'b0, 2'b01};
    tbl[11] = '{2'b00, 5'd0, 5'd0, 32'h0,         32'h0,         1'b0, 5'd0, 5'd9, 32'h0000_0077, 1'b1, 2'b00};

    reset = 1'b1;
    rd_addr = {5'd0, 5'd7, 5'd3};
    alloc_en = 1'b0; alloc_addr = '0;
    wr_en_a = '0; wr_addr_a = '0; wr_data_a = '0; wr_pc_a = '0;
    wr_en_b = '0; wr_addr_b = '0; wr_data_b = '0; wr_pc_b = '0;
    #1;
    check("reset_tv_a", 32'(tv_a), 32'd0);
    check("reset_rd_a3", rd_data_a[31:0], 32'd0);
    check("reset_busy_a", 32'(busy_a), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      wr_en_a = tbl[i].we;
      wr_addr_a = {tbl[i].wa1, tbl[i].wa0};
      wr_data_a = {tbl[i].wd1, tbl[i].wd0};
      wr_pc_a = {32'h2000 + 32'(i), 32'h1000 + 32'(i)};
      alloc_en = tbl[i].ae;
      alloc_addr = tbl[i].aa;
      rd_addr = {5'd0, 5'd0, tbl[i].ra};
      #1;
      check($sformatf("tbl%0d_rd", i), rd_data_a[31:0], tbl[i].exp_rd);
      check($sformatf("tbl%0d_busy", i), 32'(busy_a[0]), 32'(tbl[i].exp_busy));
      @(posedge clk);
      #1;
      check($sformatf("tbl%0d_tv", i), 32'(tv_a), 32'(tbl[i].exp_tv));
      if (i == 0) begin
        check("tbl0_taddr", 32'(ta_a[4:0]), 32'd3);
        check("tbl0_tdata", td_a[31:0], 32'h1234_5678);
        check("tbl0_tpc", tp_a[31:0], 32'h1000);
      end
      if (i == 2) begin
        check("tbl2_taddr1", 32'(ta_a[9:5]), 32'd7);
        check("tbl2_tdata1", td_a[63:32], 32'h5555_5555);
      end
    end

    // Fill every register with its index, then reset asynchronously mid-cycle.
    for (int r = 1; r < 32; r++) begin
      @(negedge clk);
      alloc_en = 1'b0;
      wr_en_a = 2'b01;
      wr_addr_a = {5'd0, 5'(r)};
      wr_data_a = {32'd0, 32'(r)};
    end
    @(negedge clk);
    wr_en_a = '0;
    rd_addr = {5'd31, 5'd15, 5'd1};
    #1;
    check("fill_rd31", rd_data_a[95:64], 32'd31);
    check("fill_rd15", rd_data_a[63:32], 32'd15);
    check("fill_rd1", rd_data_a[31:0], 32'd1);
    check("fill_tv", 32'(tv_a), 32'd1);
    #1 reset = 1'b1;
    #1;
    check("async_tv_a", 32'(tv_a), 32'd0);
    for (int s = 0; s < 11; s++) begin
      rd_addr = {5'(3*s+2), 5'(3*s+1), 5'(3*s)};
      #1;
      for (int k = 0; k < 3; k++)
        check($sformatf("async_rd_%0d", 3*s+k), rd_data_a[k*32 +: 32], 32'd0);
    end

    // Reset raised while a write and an alloc are in flight: both must be lost.
    @(negedge clk);
    reset = 1'b0;
    wr_en_a = 2'b01; wr_addr_a = {5'd0, 5'd5}; wr_data_a = {32'd0, 32'hDEAD_BEEF};
    alloc_en = 1'b1; alloc_addr = 5'd6;
    rd_addr = {5'd0, 5'd6, 5'd5};
    #2 reset = 1'b1;
    @(posedge clk);
    #1;
    check("midwr_tv", 32'(tv_a), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    wr_en_a = '0; alloc_en = 1'b0;
    #1;
    check("midwr_rd5", rd_data_a[31:0], 32'd0);
    check("midwr_busy6", 32'(busy_a[1]), 32'd0);

    for (int r = 0; r < 32; r++) begin
      ma[r] = '0; mb[r] = '0; pa[r] = 1'b0; pb[r] = 1'b0;
    end

    for (int n = 0; n < 1000; n++) begin
      @(negedge clk);
      wr_en_a = 2'($urandom);
      wr_addr_a = {raddr(), raddr()};
      wr_data_a = {$urandom, $urandom};
      wr_pc_a = {$urandom, $urandom};
      wr_en_b = 1'($urandom);
      wr_addr_b = raddr();
      wr_data_b = $urandom;
      wr_pc_b = $urandom;
      alloc_en = 1'($urandom);
      alloc_addr = raddr();
      rd_addr = {raddr(), raddr(), raddr()};
      #1;
      for (int k = 0; k < 3; k++) begin
        a = rd_addr[k*5 +: 5];
        check($sformatf("rnd%0d_a_rd%0d", n, k), rd_data_a[k*32 +: 32], exp_rd_a(a));
        check($sformatf("rnd%0d_a_busy%0d", n, k), 32'(busy_a[k]), 32'(pa[a] && !written_a(a)));
        check($sformatf("rnd%0d_b_rd%0d", n, k), rd_data_b[k*32 +: 32], exp_rd_b(a));
        check($sformatf("rnd%0d_b_busy%0d", n, k), 32'(busy_b[k]), 32'(pb[a] && !written_b(a)));
      end
      etv[1] = wr_en_a[1] && (wr_addr_a[9:5] != 0);
      etv[0] = wr_en_a[0] && (wr_addr_a[4:0] != 0) && !(etv[1] && wr_addr_a[9:5] == wr_addr_a[4:0]);
      @(posedge clk);
      for (int r = 1; r < 32; r++) begin
        if (written_a(5'(r))) pa[r] = 1'b0;
        if (written_b(5'(r))) pb[r] = 1'b0;
      end
      if (wr_en_a[0] && wr_addr_a[4:0] != 0) ma[wr_addr_a[4:0]] = wr_data_a[31:0];
      if (wr_en_a[1] && wr_addr_a[9:5] != 0) ma[wr_addr_a[9:5]] = wr_data_a[63:32];
      if (wr_en_b[0] && wr_addr_b != 0) mb[wr_addr_b] = wr_data_b;
      if (alloc_en && alloc_addr != 0) begin
        pa[alloc_addr] = 1'b1;
        pb[alloc_addr] = 1'b1;
      end
      #1;
      check($sformatf("rnd%0d_a_tv", n), 32'(tv_a), 32'(etv));
      for (int j = 0; j < 2; j++) begin
        if (etv[j]) begin
          check($sformatf("rnd%0d_a_taddr%0d", n, j), 32'(ta_a[j*5 +: 5]), 32'(wr_addr_a[j*5 +: 5]));
          check($sformatf("rnd%0d_a_tdata%0d", n, j), td_a[j*32 +: 32], wr_data_a[j*32 +: 32]);
          check($sformatf("rnd%0d_a_tpc%0d", n, j), tp_a[j*32 +: 32], wr_pc_a[j*32 +: 32]);
        end
      end
      check($sformatf("rnd%0d_b_tv", n), 32'(tv_b), 32'(wr_en_b[0] && wr_addr_b != 0));
      if (wr_en_b[0] && wr_addr_b != 0)
        check($sformatf("rnd%0d_b_tdata", n), td_b, wr_data_b);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/grf_mp.md
GRF_MP -- requirements
Module: grf_mp

Interface
REQ-001 SHALL have parameter DATA_W, default 32: register width in bits.
REQ-002 SHALL have parameter ADDR_W, default 5: address width; depth = 2**ADDR_W.
REQ-003 SHALL have parameter NUM_RD, default 2: number of read ports (1..4).
REQ-004 SHALL have parameter NUM_WR, default 2: number of write ports (1..2); port index NUM_WR-1 is the youngest.
REQ-005 SHALL have parameter ZERO_REG, default 1: when 1, address 0 reads zero, ignores writes, is never busy and is never traced.
REQ-006 SHALL have port clk  in  1: single clock; all state updates on posedge.
REQ-007 SHALL have port reset  in  1: asynchronous, active-high reset.
REQ-008 SHALL have port rd_addr  in  NUM_RD*ADDR_W: packed read addresses; port k uses bits [k*ADDR_W +: ADDR_W].
REQ-009 SHALL have port rd_data  out  NUM_RD*DATA_W: packed read data, combinational.
REQ-010 SHALL have port rd_busy  out  NUM_RD: the per-read-port scoreboard hazard flag.
REQ-011 SHALL have port wr_en  in  NUM_WR: per-write-port enable.
REQ-012 SHALL have port wr_addr  in  NUM_WR*ADDR_W: packed write addresses.
REQ-013 SHALL have port wr_data  in  NUM_WR*DATA_W: packed write data.
REQ-014 SHALL have port wr_pc  in  NUM_WR*32: the PC of each writing instruction, used for trace only.
REQ-015 SHALL have port alloc_en  in  1: marks a destination as pending (issue stage).
REQ-016 SHALL have port alloc_addr  in  ADDR_W: the destination being allocated.
REQ-017 SHALL have port trace_valid  out  NUM_WR: registered per-port commit strobe.
REQ-018 SHALL have port trace_addr  out  NUM_WR*ADDR_W: the registered committed address.
REQ-019 SHALL have port trace_data  out  NUM_WR*DATA_W: the registered committed data.
REQ-020 SHALL have port trace_pc  out  NUM_WR*32: the registered committed PC.

Function
REQ-021 A write port SHALL be effective when its wr_en is 1, it does not target the zero register (when ZERO_REG=1), and no higher-index port has an effective write to the same address.
REQ-022 At each posedge clk, every effective write SHALL update its register; a shadowed lower-index write SHALL be discarded.
REQ-023 rd_data[k] SHALL be 0 when rd_addr[k] is the zero register; otherwise it SHALL be the wr_data of the effective write to rd_addr[k] (same-cycle bypass); otherwise it SHALL be the stored value.
REQ-024 The register array SHALL have zero read latency and one-cycle write latency; the bypass SHALL make a write visible to reads in the same cycle.
REQ-025 A busy bit SHALL be kept per register; at posedge, alloc_en SHALL set busy[alloc_addr], and any effective write SHALL clear busy[wr_addr].
REQ-026 On alloc and write to the same address in the same cycle, allocation SHALL win and the bit SHALL remain 1, because a newer producer is pending.
REQ-027 rd_busy[k] SHALL equal busy[rd_addr[k]] AND NOT (an effective write to rd_addr[k] this cycle); it SHALL be 0 for the zero register.
REQ-028 alloc_en to the zero register (when ZERO_REG=1) SHALL be ignored.
REQ-029 An effective write on port j SHALL set trace_valid[j]=1 on the next cycle, with the address, data and PC captured; otherwise trace_valid[j]=0. Shadowed and zero-register writes SHALL NOT be traced.
REQ-030 When NUM_WR=1, the block SHALL behave as a single-write register file with internal forwarding plus a scoreboard.

Reset
REQ-031 Asserting reset SHALL immediately clear all registers, all busy bits, trace_valid, trace_addr, trace_data and trace_pc to 0, independent of clk.
REQ-032 While reset is high, writes and allocs SHALL be ignored.
REQ-033 rd_data SHALL read 0 for non-bypassed addresses during reset.
REQ-034 The first posedge after reset deassertion SHALL behave normally.
REQ-035 Reset asserted mid-write SHALL lose that write, with no trace produced.

Structure
REQ-036 Package grf_pkg SHALL hold default DATA_W, ADDR_W and NUM_RD/NUM_WR limits, and the ZERO_ADDR constant.
REQ-037 The scoreboard (busy array, set/clear priority, rd_busy lookup) SHALL be sub-module grf_scoreboard.
REQ-038 The array, bypass and trace logic SHALL live in grf_mp.

Verification
REQ-039 Reset, then write port0 addr 3 = 0x1234_5678 while port0 reads addr 3 -> rd_data = 0x1234_5678 in the same cycle; the next cycle gives trace_valid[0]=1, trace_addr=3.
REQ-040 Both ports write addr 7 (port0 0xAAAA_AAAA, port1 0x5555_5555) -> the stored value and bypass are 0x5555_5555; only trace_valid[1]=1.
REQ-041 Write 0xFFFF_FFFF to addr 0 with ZERO_REG=1 -> the read of addr 0 returns 0, with no trace and no busy.
REQ-042 alloc addr 9; read addr 9 next cycle -> rd_busy=1; write addr 9 -> rd_busy=0 in that cycle; alloc and write addr 9 together -> busy remains 1.
REQ-043 Fill all 32 registers with their index, then assert reset asynchronously mid-cycle -> all reads become 0 and trace_valid=0 before the next edge.
REQ-044 Run with NUM_RD=3, NUM_WR=1 and 1000 random ops -> rd_data and rd_busy match the reference model every cycle.
